// File: rtl/data_sram_pkg.sv
// Shared constants and helpers for the CPU data-port responder:
// confreg window base/offsets, confreg select decode and byte-lane merge.
package data_sram_pkg;

    localparam logic [15:0] CONF_BASE_DEFAULT = 16'hbfaf;

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_NUM    = 16'hf010;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;
    localparam logic [15:0] OFF_TIMER  = 16'he000;

    typedef enum logic [2:0] {
        CONF_LED,
        CONF_NUM,
        CONF_SWITCH,
        CONF_TIMER,
        CONF_NONE
    } conf_sel_e;

    // Offset is expected word-aligned (addr[1:0] already cleared by the caller).
    function automatic conf_sel_e decode_offset(input logic [15:0] offset);
        conf_sel_e sel;
        case (offset)
            OFF_LED:    sel = CONF_LED;
            OFF_NUM:    sel = CONF_NUM;
            OFF_SWITCH: sel = CONF_SWITCH;
            OFF_TIMER:  sel = CONF_TIMER;
            default:    sel = CONF_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lanes
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/bytewrite_ram.sv
// Single-port word RAM with four byte-lane write enables, read-first,
// registered output. Output holds while en is low.
module bytewrite_ram #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(2**ADDR_W)-1];

    // Read samples the old word before any lane of it is overwritten this cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU sram-like data port: word RAM plus a confreg window
// (LED, NUM, SWITCH, TIMER); rdata is registered one cycle after the en cycle.
module data_sram_responder
    import data_sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = 14,
    parameter logic [15:0] CONF_BASE  = CONF_BASE_DEFAULT,
    parameter logic [31:0] TIMER_STEP = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    // Handshake: en is the only qualifier. Every en cycle is accepted (no stall);
    // rdata for it is valid after the next posedge and held while en stays low.

    logic        conf_hit;
    logic [15:0] offset;
    conf_sel_e   conf_sel;
    logic        wr_any;
    logic        ram_en;
    logic [31:0] ram_rdata;

    logic [15:0] led_q;
    logic [31:0] num_q;
    logic [31:0] timer_q;

    logic [31:0] conf_rdata;
    logic [31:0] conf_rdata_q;
    logic        conf_hit_q;

    logic [15:0] led_next;
    logic [15:0] unused_led_hi;
    logic [31:0] num_next;
    logic [31:0] timer_inc;
    logic [31:0] timer_next;
    logic        unused_addr_lsb;

    assign conf_hit        = (sram_addr[31:16] == CONF_BASE);
    assign offset          = {sram_addr[15:2], 2'b00};
    assign conf_sel        = conf_hit ? decode_offset(offset) : CONF_NONE;
    assign wr_any          = sram_en && (sram_wen != 4'b0000);
    assign unused_addr_lsb = ^sram_addr[1:0];

    // Reset keeps the RAM untouched even when it coincides with a write.
    assign ram_en = sram_en && !conf_hit && !rst;

    bytewrite_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .wen  (sram_wen),
        .addr (sram_addr[ADDR_W+1:2]),
        .wdata(sram_wdata),
        .rdata(ram_rdata)
    );

    // Confreg read value is captured at the access edge, so TIMER reads the
    // pre-increment value and SWITCH is sampled at the read cycle.
    always_comb begin
        conf_rdata = 32'h0;
        case (conf_sel)
            CONF_LED:    conf_rdata = {16'h0, led_q};
            CONF_NUM:    conf_rdata = num_q;
            CONF_SWITCH: conf_rdata = {16'h0, switch_in};
            CONF_TIMER:  conf_rdata = timer_q;
            default:     conf_rdata = 32'h0;
        endcase
    end

    assign {unused_led_hi, led_next} = merge_lanes({16'h0, led_q}, sram_wdata, sram_wen);
    assign num_next  = merge_lanes(num_q, sram_wdata, sram_wen);
    assign timer_inc = timer_q + TIMER_STEP;

    // A TIMER write beats the increment only on the lanes it writes.
    assign timer_next = (wr_any && conf_sel == CONF_TIMER)
                      ? merge_lanes(timer_inc, sram_wdata, sram_wen)
                      : timer_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q        <= 16'h0;
            num_q        <= 32'h0;
            timer_q      <= 32'h0;
            conf_hit_q   <= 1'b1;
            conf_rdata_q <= 32'h0;
        end else begin
            timer_q <= timer_next;
            if (wr_any && conf_sel == CONF_LED) begin
                led_q <= led_next;
            end
            if (wr_any && conf_sel == CONF_NUM) begin
                num_q <= num_next;
            end
            if (sram_en) begin
                conf_hit_q   <= conf_hit;
                conf_rdata_q <= conf_rdata;
            end
        end
    end

    // After reset conf_hit_q selects the cleared confreg capture, giving rdata=0.
    assign sram_rdata = conf_hit_q ? conf_rdata_q : ram_rdata;
    assign led_out    = led_q;
    assign num_out    = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed scenarios plus a randomized
// back-to-back run checked against a behavioural model of the port.
module tb_data_sram_responder;

    localparam logic [15:0] CB = 16'hbfaf;

    logic        clk;
    logic        rst;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;

    int errors;
    int checks;

    logic [31:0] mem_m [int];
    logic [15:0] led_m;
    logic [31:0] num_m;
    logic [31:0] timer_m;
    logic [31:0] rdata_m;
    logic [31:0] exp_q [$];

    data_sram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .sram_en   (sram_en),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .switch_in (switch_in),
        .led_out   (led_out),
        .num_out   (num_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] lane_write(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] lanes);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int idx;
        if (addr[31:16] == CB) begin
            case ({addr[15:2], 2'b00})
                16'hf000: return {16'h0, led_m};
                16'hf010: return num_m;
                16'hf020: return {16'h0, switch_in};
                16'he000: return timer_m;
                default:  return 32'h0;
            endcase
        end
        idx = int'(addr[15:2]);
        return mem_m.exists(idx) ? mem_m[idx] : 32'hx;
    endfunction

    function automatic void model_edge(input logic r, input logic en, input logic [3:0] wen,
                                       input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rv;
        logic [31:0] tnext;
        logic [31:0] tmp;
        int idx;
        if (r) begin
            rdata_m = 32'h0;
            led_m   = 16'h0;
            num_m   = 32'h0;
            timer_m = 32'h0;
            return;
        end
        rv    = model_read(addr);
        tnext = timer_m + 32'd1;
        if (en) begin
            rdata_m = rv;
            exp_q.push_back(rv);
        end
        timer_m = tnext;
        if (en && wen != 4'h0) begin
            if (addr[31:16] == CB) begin
                case ({addr[15:2], 2'b00})
                    16'hf000: begin
                        tmp   = lane_write({16'h0, led_m}, wdata, wen);
                        led_m = tmp[15:0];
                    end
                    16'hf010: num_m   = lane_write(num_m, wdata, wen);
                    16'he000: timer_m = lane_write(tnext, wdata, wen);
                    default: ;
                endcase
            end else begin
                idx        = int'(addr[15:2]);
                tmp        = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
                mem_m[idx] = lane_write(tmp, wdata, wen);
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
        rst        = r;
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wdata;
        @(posedge clk);
        model_edge(r, en, wen, addr, wdata);
        #1;
        rst     = 1'b0;
        sram_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen);
        step(1'b0, 1'b1, wen, addr, data);
    endtask

    task automatic rd(input logic [31:0] addr);
        step(1'b0, 1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", sram_rdata, 32'h0); end
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want %h", led_out, 16'h0); end
        checks++; if (num_out !== 32'h0) begin errors++; $display("FAIL reset_num: got %h want %h", num_out, 32'h0); end
        rd({CB, 16'he000});
        checks++; if (sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_timer0: got %h want %h", sram_rdata, 32'h0); end
        rd({CB, 16'he000});
        checks++; if (sram_rdata !== 32'h1) begin errors++; $display("FAIL reset_timer1: got %h want %h", sram_rdata, 32'h1); end
    endtask

    task automatic test_ram_rw();
        wr(32'h0000_0010, 32'hdeadbeef, 4'hf);
        rd(32'h0000_0010);
        checks++; if (sram_rdata !== 32'hdeadbeef) begin errors++; $display("FAIL ram_rw: got %h want %h", sram_rdata, 32'hdeadbeef); end
        idle();
        checks++; if (sram_rdata !== 32'hdeadbeef) begin errors++; $display("FAIL ram_hold: got %h want %h", sram_rdata, 32'hdeadbeef); end
    endtask

    task automatic test_byte_lanes();
        wr(32'h0000_0020, 32'h11223344, 4'hf);
        wr(32'h0000_0020, 32'h0000aa00, 4'b0010);
        rd(32'h0000_0020);
        checks++; if (sram_rdata !== 32'h1122aa44) begin errors++; $display("FAIL byte_lanes: got %h want %h", sram_rdata, 32'h1122aa44); end
        rd(32'h0001_0023);
        checks++; if (sram_rdata !== 32'h1122aa44) begin errors++; $display("FAIL alias_read: got %h want %h", sram_rdata, 32'h1122aa44); end
    endtask

    task automatic test_read_first();
        wr(32'h0000_0030, 32'h5, 4'hf);
        wr(32'h0000_0030, 32'h9, 4'hf);
        checks++; if (sram_rdata !== 32'h5) begin errors++; $display("FAIL read_first_old: got %h want %h", sram_rdata, 32'h5); end
        rd(32'h0000_0030);
        checks++; if (sram_rdata !== 32'h9) begin errors++; $display("FAIL read_first_new: got %h want %h", sram_rdata, 32'h9); end
    endtask

    task automatic test_confreg();
        wr({CB, 16'hf000}, 32'hffff1234, 4'hf);
        checks++; if (led_out !== 16'h1234) begin errors++; $display("FAIL led_write: got %h want %h", led_out, 16'h1234); end
        rd({CB, 16'hf000});
        checks++; if (sram_rdata !== 32'h00001234) begin errors++; $display("FAIL led_read: got %h want %h", sram_rdata, 32'h00001234); end
        switch_in = 16'h00a5;
        rd({CB, 16'hf020});
        checks++; if (sram_rdata !== 32'h000000a5) begin errors++; $display("FAIL switch_read: got %h want %h", sram_rdata, 32'h000000a5); end
        wr({CB, 16'hf020}, 32'hdeadbeef, 4'hf);
        rd({CB, 16'hf020});
        checks++; if (sram_rdata !== 32'h000000a5) begin errors++; $display("FAIL switch_ro: got %h want %h", sram_rdata, 32'h000000a5); end
        wr({CB, 16'hf010}, 32'h12345678, 4'hf);
        wr({CB, 16'hf010}, 32'hcafe0000, 4'b1100);
        checks++; if (num_out !== 32'hcafe5678) begin errors++; $display("FAIL num_lanes: got %h want %h", num_out, 32'hcafe5678); end
        wr({CB, 16'hf030}, 32'h87654321, 4'hf);
        rd({CB, 16'hf030});
        checks++; if (sram_rdata !== 32'h0) begin errors++; $display("FAIL unmapped: got %h want %h", sram_rdata, 32'h0); end
    endtask

    task automatic test_timer();
        logic [31:0] t0;
        logic [31:0] exp;
        wr({CB, 16'he000}, 32'hfffffffe, 4'hf);
        idle();
        idle();
        rd({CB, 16'he000});
        checks++; if (sram_rdata !== 32'h0) begin errors++; $display("FAIL timer_wrap: got %h want %h", sram_rdata, 32'h0); end
        rd({CB, 16'he000});
        checks++; if (sram_rdata !== 32'h1) begin errors++; $display("FAIL timer_next: got %h want %h", sram_rdata, 32'h1); end
        t0 = timer_m + 32'd1;
        exp = {t0[31:8], 8'hab};
        wr({CB, 16'he000}, 32'h000000ab, 4'b0001);
        rd({CB, 16'he000});
        checks++; if (sram_rdata !== exp) begin errors++; $display("FAIL timer_write_wins: got %h want %h", sram_rdata, exp); end
    endtask

    task automatic test_reset_mid_access();
        wr({CB, 16'hf000}, 32'h00005555, 4'hf);
        wr({CB, 16'hf010}, 32'h00000077, 4'hf);
        wr(32'h0000_0040, 32'h01020304, 4'hf);
        rd(32'h0000_0040);
        step(1'b1, 1'b1, 4'hf, 32'h0000_0040, 32'hffffffff);
        checks++; if (sram_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h want %h", sram_rdata, 32'h0); end
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL rst_mid_led: got %h want %h", led_out, 16'h0); end
        checks++; if (num_out !== 32'h0) begin errors++; $display("FAIL rst_mid_num: got %h want %h", num_out, 32'h0); end
        rd({CB, 16'he000});
        checks++; if (sram_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_timer: got %h want %h", sram_rdata, 32'h0); end
        rd(32'h0000_0040);
        checks++; if (sram_rdata !== 32'h01020304) begin errors++; $display("FAIL rst_mid_ram: got %h want %h", sram_rdata, 32'h01020304); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pool [8];
        logic [15:0] offs [5];
        logic [31:0] addr;
        logic [31:0] exp;
        logic [31:0] held;
        logic [3:0]  wen;
        logic        en;
        logic        r;
        offs[0] = 16'hf000; offs[1] = 16'hf010; offs[2] = 16'hf020;
        offs[3] = 16'he000; offs[4] = 16'hf034;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'h100 + 32'(4 * i);
            wr(pool[i], $urandom, 4'hf);
        end
        exp_q.delete();
        held = rdata_m;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 6)
                addr = {16'($urandom_range(0, 255)), pool[$urandom_range(0, 7)][15:2], 2'($urandom_range(0, 3))};
            else
                addr = {CB, offs[$urandom_range(0, 4)]};
            en  = ($urandom_range(0, 7) != 0);
            wen = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            r   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) switch_in = 16'($urandom);
            step(r, en, wen, addr, $urandom);
            if (r) begin
                exp = 32'h0;
            end else if (en) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_queue: got empty scoreboard want 1 entry");
                    exp = held;
                end else begin
                    exp = exp_q.pop_front();
                end
            end else begin
                exp = held;
            end
            held = exp;
            checks++; if (sram_rdata !== exp) begin errors++; $display("FAIL b2b_rdata[%0d]: addr=%h got %h want %h", n, addr, sram_rdata, exp); end
            checks++; if (led_out !== led_m) begin errors++; $display("FAIL b2b_led[%0d]: got %h want %h", n, led_out, led_m); end
            checks++; if (num_out !== num_m) begin errors++; $display("FAIL b2b_num[%0d]: got %h want %h", n, num_out, num_m); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        sram_en    = 1'b0;
        sram_wen   = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        switch_in  = 16'h0;
        test_reset();
        test_ram_rw();
        test_byte_lanes();
        test_read_first();
        test_confreg();
        test_timer();
        test_reset_mid_access();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
